tcb_lib_error_responder: RTL and testbench

TCB_LIB_ERROR_RESPONDER -- requirements
Module: tcb_lib_error_responder

---
 rtl/tcb_pkg.sv | 24 ++
 rtl/tcb_if.sv | 31 +++
 rtl/tcb_lib_delay.sv | 42 ++++
 rtl/tcb_lib_error_responder.sv | 97 +++++++++
 tb/tb_tcb_lib_error_responder.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcb_pkg.sv
// Shared TCB definitions: PHY geometry, response status encoding, default
// error read-data pattern and the error-log state encoding.
package tcb_pkg;

    typedef struct packed {
        int unsigned ABW;
        int unsigned DBW;
        int unsigned DLY;
    } tcb_phy_t;

    localparam tcb_phy_t TCB_PHY_DEF = '{ABW: 32, DBW: 32, DLY: 1};

    typedef struct packed {
        logic err;
    } tcb_rsp_sts_def_t;

    localparam logic [31:0] TCB_RDT_DEF = 32'hDEAD_BEEF;

    typedef enum logic {
        LOG_EMPTY = 1'b0,
        LOG_HELD  = 1'b1
    } tcb_log_state_t;

endpackage

// File: rtl/tcb_if.sv
// TCB point-to-point bus: handshake, request and response, plus the clock and
// active-low reset that every stage on the bus shares.
interface tcb_if
    import tcb_pkg::*;
#(
    parameter tcb_phy_t PHY = TCB_PHY_DEF
)(
    input logic clk,
    input logic rst
);

    typedef struct packed {
        logic                 wen;
        logic [PHY.ABW-1:0]   adr;
        logic [PHY.DBW-1:0]   wdt;
    } req_t;

    typedef struct packed {
        logic [PHY.DBW-1:0]   rdt;
        tcb_rsp_sts_def_t     sts;
    } rsp_t;

    logic vld;
    logic rdy;
    req_t req;
    rsp_t rsp;

    modport man (input clk, input rst, output vld, output req, input rdy, input rsp);
    modport sub (input clk, input rst, input vld, input req, output rdy, output rsp);

endinterface

// File: rtl/tcb_lib_delay.sv
// Response timing line for TCB stages: carries transfer-valid and write-enable
// DLY cycles; DLY = 0 passes them straight through in the transfer cycle.
module tcb_lib_delay #(
    parameter int unsigned DLY = 1
)(
    input  logic clk,
    input  logic rst,
    input  logic trn,
    input  logic wen,
    output logic rsp_vld,
    output logic rsp_wen
);

    if (DLY == 0) begin : g_comb
        logic unused_clk;
        assign unused_clk = clk ^ rst;
        assign rsp_vld    = trn;
        assign rsp_wen    = wen;
    end else begin : g_line
        logic [DLY-1:0] vld_p;
        logic [DLY-1:0] wen_p;

        // stage 0 takes the transfer, stage DLY-1 presents the response
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_p <= '0;
                wen_p <= '0;
            end else begin
                vld_p[0] <= trn;
                wen_p[0] <= wen;
                for (int i = 1; i < DLY; i++) begin
                    vld_p[i] <= vld_p[i-1];
                    wen_p[i] <= wen_p[i-1];
                end
            end
        end

        assign rsp_vld = vld_p[DLY-1];
        assign rsp_wen = wen_p[DLY-1];
    end

endmodule

// File: rtl/tcb_lib_error_responder.sv
// Terminates unmapped TCB accesses with error responses and logs the first
// offending access (address, direction) plus a saturating transfer count.
module tcb_lib_error_responder
    import tcb_pkg::*;
#(
    parameter logic [31:0] RDT = TCB_RDT_DEF,
    parameter int unsigned CNW = 8
)(
    tcb_if.sub                     sub,
    input  logic                   clr,
    output logic                   log_vld,
    output logic [sub.PHY.ABW-1:0] log_adr,
    output logic                   log_wen,
    output logic [CNW-1:0]         cnt,
    output logic                   irq
);

    localparam int unsigned    DBW   = sub.PHY.DBW;
    localparam int unsigned    DLY   = sub.PHY.DLY;
    localparam logic [DBW-1:0] RDT_D = DBW'(RDT);

    function automatic logic [CNW-1:0] sat_inc(input logic [CNW-1:0] val);
        return (val == {CNW{1'b1}}) ? val : val + 1'b1;
    endfunction

    logic           trn;
    logic           rsp_vld;
    logic           rsp_wen;
    logic           cap;
    logic           unused_wdt;
    tcb_log_state_t state;
    tcb_log_state_t state_nxt;

    assign sub.rdy    = sub.rst;
    assign trn        = sub.vld & sub.rdy;
    assign unused_wdt = ^sub.req.wdt;

    tcb_lib_delay #(
        .DLY (DLY)
    ) u_dly (
        .clk     (sub.clk),
        .rst     (sub.rst),
        .trn     (trn),
        .wen     (sub.req.wen),
        .rsp_vld (rsp_vld),
        .rsp_wen (rsp_wen)
    );

    assign sub.rsp.sts.err = rsp_vld;
    assign sub.rsp.rdt     = (rsp_vld && !rsp_wen) ? RDT_D : '0;

    // a clear coinciding with a transfer re-arms the log on that transfer
    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        case (state)
            LOG_EMPTY: begin
                if (trn) begin
                    state_nxt = LOG_HELD;
                    cap       = 1'b1;
                end
            end
            LOG_HELD: begin
                if (trn && clr) begin
                    cap = 1'b1;
                end else if (clr) begin
                    state_nxt = LOG_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge sub.clk or negedge sub.rst) begin
        if (!sub.rst) begin
            state   <= LOG_EMPTY;
            log_adr <= '0;
            log_wen <= 1'b0;
            cnt     <= '0;
            irq     <= 1'b0;
        end else begin
            state <= state_nxt;
            irq   <= cap;
            if (cap) begin
                log_adr <= sub.req.adr;
                log_wen <= sub.req.wen;
            end
            if (trn) begin
                cnt <= clr ? CNW'(1) : sat_inc(cnt);
            end else if (clr) begin
                cnt <= '0;
            end
        end
    end

    assign log_vld = (state == LOG_HELD);

endmodule

// File: tb/tb_tcb_lib_error_responder.sv
// Bench for tcb_lib_error_responder: three instances (DLY 0/1/2, CNW 2/8/8)
// share one stimulus stream and are compared against a cycle-history model.
module tb_tcb_lib_error_responder;
    import tcb_pkg::*;

    localparam int          NK  = 3;
    localparam int          HN  = 2048;
    localparam logic [31:0] RDT = 32'hDEAD_BEEF;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld   = 1'b0;
    logic        wen   = 1'b0;
    logic        clr   = 1'b0;
    logic [31:0] adr   = '0;
    logic [31:0] wdt   = '0;

    logic [NK-1:0] o_rdy;
    logic [NK-1:0] o_err;
    logic [NK-1:0] o_lv;
    logic [NK-1:0] o_lw;
    logic [NK-1:0] o_irq;
    logic [31:0]   o_rdt [NK];
    logic [31:0]   o_la  [NK];
    logic [31:0]   o_cnt [NK];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NK; g++) begin : g_inst
        localparam tcb_phy_t    PHY = '{ABW: 32, DBW: 32, DLY: g};
        localparam int unsigned CW  = (g == 0) ? 2 : 8;
        logic [CW-1:0] cnt_l;

        tcb_if #(.PHY(PHY)) bus (.clk(clk), .rst(rst_n));

        tcb_lib_error_responder #(
            .RDT (RDT),
            .CNW (CW)
        ) dut (
            .sub     (bus),
            .clr     (clr),
            .log_vld (o_lv[g]),
            .log_adr (o_la[g]),
            .log_wen (o_lw[g]),
            .cnt     (cnt_l),
            .irq     (o_irq[g])
        );

        assign bus.vld     = vld;
        assign bus.req.wen = wen;
        assign bus.req.adr = adr;
        assign bus.req.wdt = wdt;
        assign o_rdy[g]    = bus.rdy;
        assign o_err[g]    = bus.rsp.sts.err;
        assign o_rdt[g]    = bus.rsp.rdt;
        assign o_cnt[g]    = 32'(cnt_l);
    end

    int checks = 0;
    int errors = 0;
    int t      = 0;
    int epoch  = 0;

    // per-cycle transfer history; a response is owed DLY cycles after a
    // transfer unless a reset (new epoch) came in between
    bit h_trn [HN];
    bit h_wen [HN];
    int h_ep  [HN];

    bit          m_lv  = 1'b0;
    logic [31:0] m_la  = '0;
    bit          m_lw  = 1'b0;
    bit          m_irq = 1'b0;
    int          m_cnt [NK] = '{0, 0, 0};
    int          dly_k [NK] = '{0, 1, 2};
    int          max_k [NK] = '{3, 255, 255};

    typedef struct {
        bit          v;
        bit          w;
        logic [31:0] a;
        bit          c;
        bit          e_err;
        logic [31:0] e_rdt;
        bit          e_lv;
        logic [31:0] e_la;
        bit          e_lw;
        int          e_cnt;
        bit          e_irq;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %h want %h", name, t, act, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NK; k++) begin
            int          due;
            bit          e_err;
            logic [31:0] e_rdt;
            due   = t - dly_k[k];
            e_err = 1'b0;
            e_rdt = '0;
            if (rst_n && due >= 0) begin
                if (h_trn[due] && h_ep[due] == epoch) begin
                    e_err = 1'b1;
                    e_rdt = h_wen[due] ? 32'h0 : RDT;
                end
            end
            chk($sformatf("rdy[%0d]", k), 32'(o_rdy[k]), 32'(rst_n));
            chk($sformatf("rsp_err[%0d]", k), 32'(o_err[k]), 32'(e_err));
            chk($sformatf("rsp_rdt[%0d]", k), o_rdt[k], e_rdt);
            chk($sformatf("log_vld[%0d]", k), 32'(o_lv[k]), 32'(m_lv));
            chk($sformatf("cnt[%0d]", k), o_cnt[k], 32'(m_cnt[k]));
            chk($sformatf("irq[%0d]", k), 32'(o_irq[k]), 32'(m_irq));
            if (m_lv || !rst_n) begin
                chk($sformatf("log_adr[%0d]", k), o_la[k], m_la);
                chk($sformatf("log_wen[%0d]", k), 32'(o_lw[k]), 32'(m_lw));
            end
        end
    endtask

    task automatic model_reset();
        m_lv  = 1'b0;
        m_la  = '0;
        m_lw  = 1'b0;
        m_irq = 1'b0;
        for (int k = 0; k < NK; k++) m_cnt[k] = 0;
        epoch++;
    endtask

    task automatic model_update();
        bit trn;
        bit take;
        if (!rst_n) return;
        trn   = h_trn[t];
        take  = trn && (!m_lv || clr);
        m_irq = take;
        if (take) begin
            m_lv = 1'b1;
            m_la = adr;
            m_lw = wen;
        end else if (clr) begin
            m_lv = 1'b0;
        end
        for (int k = 0; k < NK; k++) begin
            if (trn) m_cnt[k] = clr ? 1 : ((m_cnt[k] < max_k[k]) ? m_cnt[k] + 1 : max_k[k]);
            else if (clr) m_cnt[k] = 0;
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit w, input logic [31:0] a, input bit c);
        @(negedge clk);
        if (!r && rst_n) model_reset();
        rst_n    = r;
        vld      = v;
        wen      = w;
        adr      = a;
        clr      = c;
        wdt      = $urandom();
        h_trn[t] = v && r;
        h_wen[t] = w;
        h_ep[t]  = epoch;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        t++;
    endtask

    task automatic step(input bit r, input bit v, input bit w, input logic [31:0] a, input bit c);
        drive(r, v, w, a, c);
        check_all();
        advance();
    endtask

    initial begin
        vec_t        tbl [12];
        int          irqs;
        int          sat_exp [5];
        logic [31:0] ra;

        tbl[0]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 1'b0, 32'h0,    1'b0, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h1000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,    1'b0, 0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, RDT,   1'b1, 32'h1000, 1'b0, 1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 32'h20,   1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h0, 1'b1, 32'h1000, 1'b0, 2, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 32'h2000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 2, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, RDT,   1'b1, 32'h2000, 1'b0, 1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0, 1'b1, 32'h2000, 1'b0, 1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 1'b0, 32'h0,    1'b0, 0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 32'h30,   1'b0, 1'b0, 32'h0, 1'b0, 32'h0,    1'b0, 0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h0, 1'b1, 32'h30,   1'b1, 1, 1'b1};
        sat_exp = '{1, 2, 3, 3, 3};

        // reset state, with vld held high to show rdy gating
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h100, 1'b0);

        // directed table, expectations for the DLY = 1 instance
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].c);
            check_all();
            chk($sformatf("tbl%0d_err", i), 32'(o_err[1]), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_rdt", i), o_rdt[1], tbl[i].e_rdt);
            chk($sformatf("tbl%0d_lv", i), 32'(o_lv[1]), 32'(tbl[i].e_lv));
            chk($sformatf("tbl%0d_cnt", i), o_cnt[1], 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_irq", i), 32'(o_irq[1]), 32'(tbl[i].e_irq));
            if (tbl[i].e_lv) begin
                chk($sformatf("tbl%0d_la", i), o_la[1], tbl[i].e_la);
                chk($sformatf("tbl%0d_lw", i), 32'(o_lw[1]), 32'(tbl[i].e_lw));
            end
            advance();
        end

        // four back-to-back writes on the DLY = 2 instance
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        irqs = 0;
        for (int j = 0; j < 7; j++) begin
            drive(1'b1, j < 4, 1'b1, 32'h10 + 32'(4 * j), 1'b0);
            check_all();
            chk($sformatf("b2b_err%0d", j), 32'(o_err[2]), 32'(j >= 2 && j <= 5));
            if (o_irq[2]) irqs++;
            advance();
        end
        chk("b2b_irqs", 32'(irqs), 32'd1);
        chk("b2b_cnt", o_cnt[2], 32'd4);
        chk("b2b_log_adr", o_la[2], 32'h10);

        // saturation on the CNW = 2 instance
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h40 + 32'(i), 1'b0);
            #1;
            chk($sformatf("sat_cnt%0d", i), o_cnt[0], 32'(sat_exp[i]));
        end

        // combinational response at DLY = 0
        drive(1'b1, 1'b1, 1'b0, 32'h4, 1'b0);
        check_all();
        chk("dly0_err", 32'(o_err[0]), 32'd1);
        chk("dly0_rdt", o_rdt[0], RDT);
        advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_all();
        chk("dly0_idle_err", 32'(o_err[0]), 32'd0);
        chk("dly0_idle_rdt", o_rdt[0], 32'h0);
        advance();

        // reset one cycle after a transfer discards the DLY = 2 response
        step(1'b1, 1'b1, 1'b0, 32'h50, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h58, 1'b0);
            check_all();
            chk($sformatf("rst_err%0d", i), 32'(o_err[2]), 32'd0);
            chk($sformatf("rst_rdy%0d", i), 32'(o_rdy[2]), 32'd0);
            chk($sformatf("rst_cnt%0d", i), o_cnt[2], 32'd0);
            advance();
        end
        step(1'b1, 1'b1, 1'b0, 32'h60, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_all();
        chk("post_rst_err", 32'(o_err[2]), 32'd1);
        chk("post_rst_rdt", o_rdt[2], RDT);
        chk("post_rst_adr", o_la[2], 32'h60);
        advance();

        // randomized traffic with occasional clears and reset pulses
        for (int i = 0; i < 500; i++) begin
            ra = $urandom();
            step($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 70, 1'($urandom()),
                 {ra[31:2], 2'b00}, $urandom_range(0, 99) < 10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
